// File: rtl/plasma_avalon_pio_master.sv
// ----------------------------------------------------------------------------
// plasma_avalon_pio_master
//
// Avalon-MM initiator that turns one Plasma CPU bus request at a time into a
// single write strobe or read strobe toward a PIO-style Avalon slave. Reads
// wait the slave's fixed read latency, capture avm_readdata and finish with
// a one-cycle acknowledge. The slave irq is registered toward the CPU
// interrupt controller.
//
// Ports:
//   clk            system clock, all logic rising-edge
//   reset          asynchronous active-high reset
//   cpu_req        request valid, held until cpu_ack
//   cpu_we         1 = write, 0 = read
//   cpu_addr       CPU byte address (bits [ADDR_WIDTH+1:2] used)
//   cpu_wdata      CPU write data
//   cpu_rdata      captured read data, held until the next read capture
//   cpu_ack        one-cycle completion pulse
//   cpu_busy       high whenever the state machine is not idle
//   cpu_irq        registered copy of avm_irq
//   avm_address    word address to the slave
//   avm_chipselect transfer strobe
//   avm_write_n    active-low write qualifier
//   avm_writedata  write data to the slave
//   avm_readdata   slave read data
//   avm_irq        slave interrupt, level
// ----------------------------------------------------------------------------
module plasma_avalon_pio_master #(
   parameter int ADDR_WIDTH   = 2,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [31:0]           cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ack,
   output logic                  cpu_busy,
   output logic                  cpu_irq,
   output logic [ADDR_WIDTH-1:0] avm_address,
   output logic                  avm_chipselect,
   output logic                  avm_write_n,
   output logic [DATA_WIDTH-1:0] avm_writedata,
   input  logic [DATA_WIDTH-1:0] avm_readdata,
   input  logic                  avm_irq
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WSTROBE = 3'd1;
   localparam logic [2:0] ST_RSTROBE = 3'd2;
   localparam logic [2:0] ST_RWAIT   = 3'd3;
   localparam logic [2:0] ST_ACK     = 3'd4;

   localparam logic [2:0] LAT = 3'(READ_LATENCY);

   logic [2:0]            state_r;
   logic [2:0]            state_s;
   logic [2:0]            cnt_r;
   logic [2:0]            cnt_s;
   logic [ADDR_WIDTH-1:0] addr_s;
   logic [DATA_WIDTH-1:0] wdata_s;
   logic [DATA_WIDTH-1:0] rdata_s;
   logic                  cs_s;
   logic                  write_n_s;
   logic                  ack_s;
   logic                  busy_s;

   // Only the word-address bits reach the slave; there is no decode here.
   logic unused_addr_s;
   assign unused_addr_s = ^{cpu_addr[31:ADDR_WIDTH+2], cpu_addr[1:0]};

   // Next-state, datapath and latency-counter logic.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      addr_s  = avm_address;
      wdata_s = avm_writedata;
      rdata_s = cpu_rdata;
      case (state_r)
         ST_IDLE: begin
            if (cpu_req) begin
               addr_s = cpu_addr[ADDR_WIDTH+1:2];
               if (cpu_we) begin
                  wdata_s = cpu_wdata;
                  state_s = ST_WSTROBE;
               end else begin
                  state_s = ST_RSTROBE;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WSTROBE: begin
            state_s = ST_ACK;
         end
         ST_RSTROBE: begin
            cnt_s   = LAT;
            state_s = ST_RWAIT;
         end
         ST_RWAIT: begin
            // A count of 0 cannot occur legally; treat it like 1 so the
            // machine can never stall in RWAIT.
            if (cnt_r <= 3'd1) begin
               rdata_s = avm_readdata;
               cnt_s   = 3'd0;
               state_s = ST_ACK;
            end else begin
               cnt_s   = cnt_r - 3'd1;
               state_s = ST_RWAIT;
            end
         end
         ST_ACK: begin
            state_s = ST_IDLE;
         end
         default: begin
            cnt_s   = 3'd0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // Output strobes decoded from the next state so they can be registered
   // and still line up with the state they belong to.
   always_comb begin
      cs_s      = (state_s == ST_WSTROBE) || (state_s == ST_RSTROBE);
      write_n_s = (state_s != ST_WSTROBE);
      ack_s     = (state_s == ST_ACK);
      busy_s    = (state_s != ST_IDLE);
   end

   // State, counter and registered bus outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         cnt_r          <= 3'd0;
         avm_address    <= {ADDR_WIDTH{1'b0}};
         avm_writedata  <= {DATA_WIDTH{1'b0}};
         avm_chipselect <= 1'b0;
         avm_write_n    <= 1'b1;
         cpu_rdata      <= {DATA_WIDTH{1'b0}};
         cpu_ack        <= 1'b0;
         cpu_busy       <= 1'b0;
      end else begin
         state_r        <= state_s;
         cnt_r          <= cnt_s;
         avm_address    <= addr_s;
         avm_writedata  <= wdata_s;
         avm_chipselect <= cs_s;
         avm_write_n    <= write_n_s;
         cpu_rdata      <= rdata_s;
         cpu_ack        <= ack_s;
         cpu_busy       <= busy_s;
      end
   end

   // Interrupt pass-through, one register stage, independent of the FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_irq <= 1'b0;
      end else begin
         cpu_irq <= avm_irq;
      end
   end

endmodule

// File: tb/tb_plasma_avalon_pio_master.sv
// ----------------------------------------------------------------------------
// Bench for plasma_avalon_pio_master: one instance with READ_LATENCY=1 and one
// with READ_LATENCY=3, each attached to a small PIO-like slave model
// (word 0 = in_port, words 1..3 writable, readdata pipelined by the latency).
// ----------------------------------------------------------------------------
module tb_plasma_avalon_pio_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1, rst3, tb_init;
   logic        req1, req3, we;
   logic [31:0] addr, wdata;
   logic [31:0] in_port1, in_port3;
   logic [31:0] irq_mask;

   logic [31:0] rdata1, rdata3, wd1, wd3, rd1, rd3;
   logic        ack1, ack3, busy1, busy3, irq1, irq3;
   logic        cs1, cs3, wn1, wn3, airq1, airq3;
   logic [1:0]  adr1, adr3;

   plasma_avalon_pio_master #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .READ_LATENCY(1)) dut1 (
      .clk(clk), .reset(rst1), .cpu_req(req1), .cpu_we(we), .cpu_addr(addr),
      .cpu_wdata(wdata), .cpu_rdata(rdata1), .cpu_ack(ack1), .cpu_busy(busy1),
      .cpu_irq(irq1), .avm_address(adr1), .avm_chipselect(cs1),
      .avm_write_n(wn1), .avm_writedata(wd1), .avm_readdata(rd1), .avm_irq(airq1));

   plasma_avalon_pio_master #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .READ_LATENCY(3)) dut3 (
      .clk(clk), .reset(rst3), .cpu_req(req3), .cpu_we(we), .cpu_addr(addr),
      .cpu_wdata(wdata), .cpu_rdata(rdata3), .cpu_ack(ack3), .cpu_busy(busy3),
      .cpu_irq(irq3), .avm_address(adr3), .avm_chipselect(cs3),
      .avm_write_n(wn3), .avm_writedata(wd3), .avm_readdata(rd3), .avm_irq(airq3));

   // ---------------- slave models ----------------
   logic [31:0] mem1 [0:3];
   logic [31:0] mem3 [0:3];
   logic [31:0] sel1, sel3, p3_0, p3_1;

   assign sel1  = (adr1 == 2'd0) ? in_port1 : mem1[adr1];
   assign sel3  = (adr3 == 2'd0) ? in_port3 : mem3[adr3];
   assign airq1 = in_port1[0] & irq_mask[0];
   assign airq3 = in_port3[0] & irq_mask[0];

   always @(posedge clk) begin
      if (tb_init) begin
         mem1[1] <= 32'd0; mem1[2] <= 32'd0; mem1[3] <= 32'd0;
      end else if (cs1 && !wn1) begin
         mem1[adr1] <= wd1;
      end
      rd1 <= sel1;
   end

   always @(posedge clk) begin
      if (tb_init) begin
         mem3[1] <= 32'd0; mem3[2] <= 32'd3; mem3[3] <= 32'd0;
      end else if (cs3 && !wn3) begin
         mem3[adr3] <= wd3;
      end
      p3_0 <= sel3;
      p3_1 <= p3_0;
      rd3  <= p3_1;
   end

   // Event counters: chipselect cycles on dut1, acknowledges on dut3.
   int cs_cnt1 = 0;
   int ack_cnt3 = 0;
   always @(posedge clk) begin
      if (cs1) cs_cnt1 <= cs_cnt1 + 1;
      if (ack3) ack_cnt3 <= ack_cnt3 + 1;
   end

   // ---------------- checking ----------------
   int total = 0;
   int passed = 0;
   int failed = 0;
   logic [31:0] sb_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pop the oldest expected read value and compare it against cpu_rdata.
   task automatic sb_check(input string tag, input logic [31:0] obs);
      logic [31:0] exp;
      if (sb_q.size() == 0) begin
         exp = 32'hDEAD_BEEF;
      end else begin
         exp = sb_q.pop_front();
      end
      chk(tag, obs, exp);
   endtask

   // One complete transaction on the selected instance with a bounded wait.
   task automatic txn(input bit sel3, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd);
      int n;
      logic got;
      addr = a; we = w; wdata = d;
      if (sel3) req3 = 1'b1; else req1 = 1'b1;
      if (!w) sb_q.push_back(exp_rd);
      n = 0;
      step();
      got = sel3 ? ack3 : ack1;
      while (got !== 1'b1 && n < 20) begin
         step();
         got = sel3 ? ack3 : ack1;
         n++;
      end
      chk("txn_ack_seen", 32'(got), 32'd1);
      req1 = 1'b0; req3 = 1'b0;
      if (!w) sb_check("txn_rdata", sel3 ? rdata3 : rdata1);
      step();
   endtask

   int   cs_base, ack_base;
   logic exp_irq, ack_seen;

   initial begin
      rst1 = 1'b1; rst3 = 1'b1; tb_init = 1'b1;
      req1 = 1'b0; req3 = 1'b0; we = 1'b0;
      addr = 32'd0; wdata = 32'd0;
      in_port1 = 32'h0000_000A; in_port3 = 32'd0; irq_mask = 32'h0000_0001;
      step(); step();

      // Reset state
      chk("rst_cs",    32'(cs1),   32'd0);
      chk("rst_wn",    32'(wn1),   32'd1);
      chk("rst_adr",   32'(adr1),  32'd0);
      chk("rst_wd",    wd1,        32'd0);
      chk("rst_rdata", rdata1,     32'd0);
      chk("rst_ack",   32'(ack1),  32'd0);
      chk("rst_busy",  32'(busy1), 32'd0);
      chk("rst_irq",   32'(irq1),  32'd0);
      rst1 = 1'b0; rst3 = 1'b0; tb_init = 1'b0;
      step();

      // Write 0x5 to byte address 0x8 on the latency-1 instance
      addr = 32'h8; we = 1'b1; wdata = 32'h5; req1 = 1'b1;
      step();
      chk("wr_c1_adr",  32'(adr1),  32'd2);
      chk("wr_c1_cs",   32'(cs1),   32'd1);
      chk("wr_c1_wn",   32'(wn1),   32'd0);
      chk("wr_c1_wd",   wd1,        32'h5);
      chk("wr_c1_busy", 32'(busy1), 32'd1);
      step();
      chk("wr_c2_cs",   32'(cs1),   32'd0);
      chk("wr_c2_wn",   32'(wn1),   32'd1);
      chk("wr_c2_ack",  32'(ack1),  32'd1);
      req1 = 1'b0;
      step();
      chk("wr_c3_ack",  32'(ack1),  32'd0);
      chk("wr_c3_busy", 32'(busy1), 32'd0);

      // Read in_port (0xA) at address 0, latency 1
      addr = 32'h0; we = 1'b0; req1 = 1'b1; sb_q.push_back(32'h0000_000A);
      step();
      chk("rd1_c1_cs",  32'(cs1),  32'd1);
      chk("rd1_c1_wn",  32'(wn1),  32'd1);
      chk("rd1_c1_adr", 32'(adr1), 32'd0);
      step();
      chk("rd1_c2_cs",  32'(cs1),  32'd0);
      chk("rd1_c2_adr", 32'(adr1), 32'd0);
      chk("rd1_c2_ack", 32'(ack1), 32'd0);
      step();
      chk("rd1_c3_ack", 32'(ack1), 32'd1);
      sb_check("rd1_c3_rdata", rdata1);
      req1 = 1'b0;
      step();

      // Back-to-back: write 0xF to 0x8, then read 0x8
      cs_base = cs_cnt1;
      addr = 32'h8; we = 1'b1; wdata = 32'hF; req1 = 1'b1;
      step();
      chk("b2b_wr_cs", 32'(cs1), 32'd1);
      step();
      chk("b2b_wr_ack", 32'(ack1), 32'd1);
      we = 1'b0; sb_q.push_back(32'h0000_000F);
      step();
      chk("b2b_idle_busy", 32'(busy1), 32'd0);
      chk("b2b_idle_cs",   32'(cs1),   32'd0);
      step();
      chk("b2b_rd_cs", 32'(cs1), 32'd1);
      chk("b2b_rd_wn", 32'(wn1), 32'd1);
      step();
      step();
      chk("b2b_rd_ack", 32'(ack1), 32'd1);
      sb_check("b2b_rd_rdata", rdata1);
      req1 = 1'b0;
      step();
      chk("b2b_cs_pulses", 32'(cs_cnt1 - cs_base), 32'd2);

      // A write leaves cpu_rdata untouched
      txn(1'b0, 1'b1, 32'hC, 32'h1, 32'd0);
      chk("wr_keeps_rdata", rdata1, 32'h0000_000F);

      // Latency-3 read of address 0x8 (model holds 0x3)
      addr = 32'h8; we = 1'b0; req3 = 1'b1; sb_q.push_back(32'h3);
      step();
      chk("rd3_c1_cs", 32'(cs3), 32'd1);
      step();
      chk("rd3_c2_cs",   32'(cs3),   32'd0);
      chk("rd3_c2_adr",  32'(adr3),  32'd2);
      chk("rd3_c2_busy", 32'(busy3), 32'd1);
      step();
      chk("rd3_c3_ack", 32'(ack3), 32'd0);
      step();
      chk("rd3_c4_ack", 32'(ack3), 32'd0);
      chk("rd3_c4_adr", 32'(adr3), 32'd2);
      step();
      chk("rd3_c5_ack", 32'(ack3), 32'd1);
      sb_check("rd3_c5_rdata", rdata3);
      req3 = 1'b0;
      step();

      // Reset in RWAIT on the latency-3 instance
      txn(1'b1, 1'b1, 32'hC, 32'h7, 32'd0);
      ack_base = ack_cnt3;
      addr = 32'h4; we = 1'b0; req3 = 1'b1;
      step();
      step();
      rst3 = 1'b1;
      #1;
      chk("mrst_cs",    32'(cs3),   32'd0);
      chk("mrst_wn",    32'(wn3),   32'd1);
      chk("mrst_adr",   32'(adr3),  32'd0);
      chk("mrst_wd",    wd3,        32'd0);
      chk("mrst_ack",   32'(ack3),  32'd0);
      chk("mrst_busy",  32'(busy3), 32'd0);
      chk("mrst_rdata", rdata3,     32'd0);
      req3 = 1'b0;
      step();
      rst3 = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("mrst_no_ack", 32'(ack_cnt3 - ack_base), 32'd0);
      txn(1'b1, 1'b0, 32'h8, 32'd0, 32'h3);

      // irq follows avm_irq by one cycle, also during an active read
      in_port3 = 32'd0;
      step();
      exp_irq = 1'b0;
      ack_seen = 1'b0;
      addr = 32'h4; we = 1'b0; req3 = 1'b1; sb_q.push_back(32'h0);
      for (int i = 0; i < 10; i++) begin
         in_port3 = {31'd0, (i % 3) != 0};
         exp_irq = in_port3[0] & irq_mask[0];
         step();
         chk("irq_follow", 32'(irq3), 32'(exp_irq));
         if (ack3 === 1'b1 && !ack_seen) begin
            ack_seen = 1'b1;
            sb_check("irq_rd_rdata", rdata3);
            req3 = 1'b0;
         end
      end
      chk("irq_rd_ack_seen", 32'(ack_seen), 32'd1);
      req3 = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
